// File: rtl/mul_div_sequencer_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// ALU M-op encodings, sequencer states and small op-decode helpers.
package mul_div_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    // MULHU and REMU read the upper half of the accumulator.
    function automatic logic op_takes_high(input op_e op);
        return (op == OP_MULHU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/mul_div_sequencer_if.sv
// EX-stage <-> multiply/divide sequencer handshake bundle.
// master = pipeline side, slave = sequencer side.
interface mul_div_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            flush;
    logic            result_ready;
    logic            stall_req;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1_val, rs2_val, flush, result_ready,
        input  stall_req, busy, result_valid, result
    );

    modport slave (
        input  start, op, rs1_val, rs2_val, flush, result_ready,
        output stall_req, busy, result_valid, result
    );
endinterface

// File: rtl/mul_div_step.sv
// One iteration of the shared datapath: LSB-first shift-add multiply or one
// restoring-divide step, both on a {hi, lo} 2*XLEN accumulator.
module mul_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_out
);
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;

    always_comb begin
        hi      = acc_in[2*XLEN-1:XLEN];
        lo      = acc_in[XLEN-1:0];
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        rem_sh  = {hi, lo[XLEN-1]};
        diff    = rem_sh - {1'b0, operand};
        acc_out = '0;
        // A zero divisor never borrows, so the quotient fills with ones and the
        // remainder ends up holding the dividend without special casing.
        if (is_div) begin
            if (!diff[XLEN]) begin
                acc_out = {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
            end else begin
                acc_out = {rem_sh[XLEN-1:0], lo[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_out = {sum, lo[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/mul_div_sequencer.sv
// Multi-cycle M-extension sequencer: IDLE/BUSY/DONE control, iteration
// counter, operand/accumulator/result registers and pipeline stall request.
module mul_div_sequencer
    import mul_div_sequencer_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic                clk,
    input logic                reset,
    mul_div_sequencer_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] acc_step;
    logic              step_is_div;

    always_comb step_is_div = op_is_div(op_q);

    mul_div_step #(.XLEN(XLEN)) u_step (
        .is_div  (step_is_div),
        .acc_in  (acc_q),
        .operand (opb_q),
        .acc_out (acc_step)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            opb_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start && !bus.flush) state_d = ST_BUSY;
            ST_BUSY: begin
                if (bus.flush)             state_d = ST_IDLE;
                else if (cnt_q == LAST_CNT) state_d = ST_DONE;
            end
            ST_DONE: if (bus.flush || bus.result_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter runs 0..XLEN: XLEN iterations, then one cycle registering the
    // selected half so DONE presents a stable, already-muxed result.
    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        opb_d = opb_q;
        acc_d = acc_q;
        res_d = res_q;
        if (state_q == ST_IDLE && state_d == ST_BUSY) begin
            cnt_d = '0;
            op_d  = op_e'(bus.op);
            opb_d = bus.rs2_val;
            acc_d = {{XLEN{1'b0}}, bus.rs1_val};
        end else if (state_q == ST_BUSY && state_d == ST_BUSY) begin
            acc_d = acc_step;
            cnt_d = cnt_q + CNT_W'(1);
        end else if (state_q == ST_BUSY && state_d == ST_DONE) begin
            res_d = op_takes_high(op_q) ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        end
    end

    always_comb begin
        bus.busy         = (state_q == ST_BUSY) || (state_q == ST_DONE);
        bus.result_valid = (state_q == ST_DONE);
        bus.result       = (state_q == ST_DONE) ? res_q : '0;
        bus.stall_req    = reset &&
                           (((state_q == ST_IDLE) && bus.start && !bus.flush) ||
                            (state_q == ST_BUSY) ||
                            ((state_q == ST_DONE) && !bus.result_ready));
    end
endmodule

// File: tb/tb_mul_div_sequencer.sv
// Self-checking bench for mul_div_sequencer: directed corner cases plus
// randomized ops against a plain-arithmetic reference model.
module tb_mul_div_sequencer;
    localparam int unsigned XLEN = 32;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mul_div_sequencer_if #(.XLEN(XLEN)) bus ();

    mul_div_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [XLEN-1:0] got,
                            input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] model(input logic [1:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] p;
        p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        case (op)
            2'b00:   return p[XLEN-1:0];
            2'b01:   return p[2*XLEN-1:XLEN];
            2'b10:   return (b == '0) ? '1 : a / b;
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        bus.start   = 1'($urandom);
        bus.op      = 2'($urandom);
        bus.rs1_val = $urandom;
        bus.rs2_val = $urandom;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"},  XLEN'(bus.busy), '0);
        check_eq({tag, "_valid"}, XLEN'(bus.result_valid), '0);
        check_eq({tag, "_result"}, bus.result, '0);
    endtask

    // Issue one op, verify fixed latency, hold in DONE for ready_delay cycles,
    // then consume while start is held high and confirm it is not re-taken.
    task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input int unsigned ready_delay);
        logic [XLEN-1:0] exp;
        exp = model(op, a, b);
        bus.start = 1'b1; bus.op = op; bus.rs1_val = a; bus.rs2_val = b;
        bus.flush = 1'b0; bus.result_ready = 1'b0;
        #1;
        check_eq("issue_stall", XLEN'(bus.stall_req), 1);
        tick();
        check_eq("busy_after_issue", XLEN'(bus.busy), 1);
        for (int unsigned i = 0; i < XLEN; i++) begin
            scramble_inputs();
            tick();
        end
        check_eq("valid_early", XLEN'(bus.result_valid), 0);
        check_eq("stall_busy", XLEN'(bus.stall_req), 1);
        tick();
        check_eq("valid_latency", XLEN'(bus.result_valid), 1);
        check_eq($sformatf("result_op%0d", op), bus.result, exp);
        for (int unsigned i = 0; i < ready_delay; i++) begin
            check_eq("hold_stall", XLEN'(bus.stall_req), 1);
            check_eq("hold_result", bus.result, exp);
            scramble_inputs();
            tick();
            check_eq("hold_valid", XLEN'(bus.result_valid), 1);
        end
        bus.result_ready = 1'b1;
        bus.start = 1'b1;
        #1;
        check_eq("consume_stall", XLEN'(bus.stall_req), 0);
        tick();
        check_idle_outputs("consumed");
        bus.start = 1'b0;
        bus.result_ready = 1'b0;
        #1;
        check_eq("idle_stall", XLEN'(bus.stall_req), 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.rs1_val = '0; bus.rs2_val = '0;
        bus.flush = 1'b0; bus.result_ready = 1'b0;
        repeat (3) tick();
        bus.start = 1'b1;
        #1;
        check_eq("rst_stall", XLEN'(bus.stall_req), 0);
        check_idle_outputs("rst");
        bus.start = 1'b0;
        reset = 1'b1;
        tick();
        check_idle_outputs("post_rst");

        run_op(2'b00, 32'd7, 32'd6, 0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_op(2'b10, 32'd100, 32'd7, 0);
        run_op(2'b11, 32'd100, 32'd7, 0);
        run_op(2'b10, 32'd5, 32'd0, 0);
        run_op(2'b11, 32'd5, 32'd0, 3);

        // Flush on the tenth BUSY cycle.
        bus.start = 1'b1; bus.op = 2'b00; bus.rs1_val = 32'd3; bus.rs2_val = 32'd9;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        #1;
        check_idle_outputs("flush");
        check_eq("flush_stall", XLEN'(bus.stall_req), 0);
        repeat (40) begin
            tick();
            check_eq("flush_no_valid", XLEN'(bus.result_valid), 0);
        end
        run_op(2'b10, 32'd1000, 32'd33, 0);

        // Reset on the twentieth BUSY cycle.
        bus.start = 1'b1; bus.op = 2'b01; bus.rs1_val = $urandom; bus.rs2_val = $urandom;
        tick();
        bus.start = 1'b0;
        repeat (19) tick();
        reset = 1'b0;
        tick();
        check_idle_outputs("mid_rst");
        check_eq("mid_rst_stall", XLEN'(bus.stall_req), 0);
        reset = 1'b1;
        tick();
        check_idle_outputs("mid_rst_rel");

        // Start together with flush in IDLE must not issue.
        bus.start = 1'b1; bus.flush = 1'b1;
        #1;
        check_eq("flush_idle_stall", XLEN'(bus.stall_req), 0);
        tick();
        check_eq("flush_idle_busy", XLEN'(bus.busy), 0);
        bus.start = 1'b0; bus.flush = 1'b0;
        tick();

        for (int i = 0; i < 40; i++) begin
            logic [XLEN-1:0] a;
            logic [XLEN-1:0] b;
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? '0 :
                ($urandom_range(0, 1) == 0) ? XLEN'($urandom_range(1, 255)) : $urandom;
            run_op(2'($urandom), a, b, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
